// File: rtl/seg_bcd_conv.sv
// seg_bcd_conv: converts the held 20-bit millivolt value to six packed BCD
// digits with a sequential shift-add-3 engine, and derives a leading-zero
// blanking mask for the downstream seven-segment scanner.
module seg_bcd_conv #(
  parameter logic        BLANK_EN = 1'b1,
  parameter logic [19:0] SAT_VAL  = 20'd999_999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] data,
  output logic [23:0] bcd,
  output logic [5:0]  blank,
  output logic        ovf,
  output logic        busy,
  output logic        bcd_valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Blank pattern that represents a displayed value of 0.
  localparam logic [5:0] BLANK_RST = BLANK_EN ? 6'b111110 : 6'b000000;

  state_t      state;
  logic [19:0] last_data;
  logic [19:0] bin_sh;
  logic [23:0] bcd_sh;
  logic [4:0]  cnt;
  logic        ovf_sh;

  logic [23:0] bcd_adj;
  logic [5:0]  blank_nxt;
  logic        zero_run;

  // Add-3 correction on every BCD nibble that is 5 or more, ahead of the shift.
  always_comb begin
    bcd_adj = bcd_sh;
    for (int unsigned i = 0; i < 6; i++) begin
      if (bcd_sh[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_sh[4*i +: 4] + 4'd3;
      end
    end
  end

  // Leading-zero mask: a digit blanks only if it and all digits above it are 0.
  always_comb begin
    blank_nxt = '0;
    zero_run  = 1'b1;
    for (int unsigned i = 5; i >= 1; i--) begin
      zero_run     = zero_run & (bcd_sh[4*i +: 4] == 4'd0);
      blank_nxt[i] = zero_run & BLANK_EN;
    end
  end

  // Conversion FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last_data <= '0;
      bin_sh    <= '0;
      bcd_sh    <= '0;
      cnt       <= '0;
      ovf_sh    <= 1'b0;
      bcd       <= '0;
      blank     <= BLANK_RST;
      ovf       <= 1'b0;
      busy      <= 1'b0;
      bcd_valid <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (data != last_data) begin
            last_data <= data;
            if (data > SAT_VAL) begin
              bin_sh <= SAT_VAL;
              ovf_sh <= 1'b1;
            end else begin
              bin_sh <= data;
              ovf_sh <= 1'b0;
            end
            bcd_sh <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_sh <= {bcd_adj[22:0], bin_sh[19]};
          bin_sh <= {bin_sh[18:0], 1'b0};
          cnt    <= cnt + 5'd1;
          if (cnt == 5'd19) begin
            state <= DONE;
          end
        end
        DONE: begin
          bcd       <= bcd_sh;
          ovf       <= ovf_sh;
          blank     <= blank_nxt;
          bcd_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
